// File: rtl/ddr3_ctrl_pkg.sv
// Shared command/request types for the CPU-side path into the DDR3 controller.
package ddr3_ctrl_pkg;

    localparam int DEF_ADDR_W = 27;  // row 14 + bank 3 + col 10
    localparam int DEF_DATA_W = 64;

    typedef enum logic {
        CMD_RD = 1'b0,
        CMD_WR = 1'b1
    } cmd_e;

    typedef struct packed {
        cmd_e                  cmd;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_req_queue.sv
// In-order CPU request buffer in front of the DDR3 controller with a cap on
// in-flight reads and a one-cycle registered read-data return path.
module cpu_req_queue
    import ddr3_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 8,
    parameter int MAX_RD = 4
) (
    input  logic                        i_cpu_ck,
    input  logic                        i_cpu_rst_n,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic                        i_req_cmd,
    input  logic [ADDR_W-1:0]           i_req_addr,
    input  logic [DATA_W-1:0]           i_req_wdata,
    output logic                        o_ctl_valid,
    input  logic                        i_ctl_ready,
    output logic                        o_ctl_cmd,
    output logic [ADDR_W-1:0]           o_ctl_addr,
    output logic [DATA_W-1:0]           o_ctl_wdata,
    input  logic                        i_ctl_rvalid,
    input  logic [DATA_W-1:0]           i_ctl_rdata,
    output logic                        o_cpu_rvalid,
    output logic [DATA_W-1:0]           o_cpu_rdata,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [$clog2(MAX_RD):0]     o_rd_outstanding,
    output logic                        o_error
);

    localparam int RO_W = $clog2(MAX_RD) + 1;
    localparam logic [RO_W-1:0] RD_CAP = RO_W'(MAX_RD);

    typedef struct packed {
        cmd_e              cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t            in_entry;
    entry_t            head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_is_rd;
    logic              rd_pop;
    logic              rd_ret;
    logic [RO_W-1:0]   rd_out_p1;
    logic              error_p1;
    logic              cpu_rvalid_p1;
    logic [DATA_W-1:0] cpu_rdata_p1;

    assign in_entry.cmd   = cmd_e'(i_req_cmd);
    assign in_entry.addr  = i_req_addr;
    assign in_entry.wdata = i_req_wdata;

    assign o_req_ready = !full;
    assign push        = i_req_valid && o_req_ready;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_cpu_ck),
        .rst_n (i_cpu_rst_n),
        .push  (push),
        .wdata (in_entry),
        .pop   (pop),
        .rdata (head),
        .count (o_count),
        .full  (full),
        .empty (empty)
    );

    // A capped read at the head stalls everything behind it to keep order strict.
    assign head_is_rd  = (head.cmd == CMD_RD);
    assign o_ctl_valid = !empty && !(head_is_rd && (rd_out_p1 == RD_CAP));
    assign pop         = o_ctl_valid && i_ctl_ready;
    assign o_ctl_cmd   = head.cmd;
    assign o_ctl_addr  = head.addr;
    assign o_ctl_wdata = head.wdata;

    assign rd_pop = pop && head_is_rd;
    assign rd_ret = i_ctl_rvalid && (rd_out_p1 != '0);

    // Stage p1: read accounting, sticky error and registered return path.
    always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
        if (!i_cpu_rst_n) begin
            rd_out_p1     <= '0;
            error_p1      <= 1'b0;
            cpu_rvalid_p1 <= 1'b0;
            cpu_rdata_p1  <= '0;
        end else begin
            case ({rd_pop, rd_ret})
                2'b10:   rd_out_p1 <= rd_out_p1 + RO_W'(1);
                2'b01:   rd_out_p1 <= rd_out_p1 - RO_W'(1);
                default: rd_out_p1 <= rd_out_p1;
            endcase
            if (i_ctl_rvalid && (rd_out_p1 == '0)) begin
                error_p1 <= 1'b1;
            end
            cpu_rvalid_p1 <= i_ctl_rvalid;
            if (i_ctl_rvalid) begin
                cpu_rdata_p1 <= i_ctl_rdata;
            end
        end
    end

    assign o_rd_outstanding = rd_out_p1;
    assign o_error          = error_p1;
    assign o_cpu_rvalid     = cpu_rvalid_p1;
    assign o_cpu_rdata      = cpu_rdata_p1;

endmodule

// File: tb/tb_cpu_req_queue.sv
// Directed bench for cpu_req_queue with hand-computed expectations.
module tb_cpu_req_queue;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int MAX_RD = 4;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ctl_valid;
    logic              ctl_ready;
    logic              ctl_cmd;
    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_wdata;
    logic              ctl_rvalid;
    logic [DATA_W-1:0] ctl_rdata;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [3:0]        count;
    logic [2:0]        rd_outstanding;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_req_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .MAX_RD (MAX_RD)
    ) dut (
        .i_cpu_ck         (clk),
        .i_cpu_rst_n      (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_cmd        (req_cmd),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_ctl_valid      (ctl_valid),
        .i_ctl_ready      (ctl_ready),
        .o_ctl_cmd        (ctl_cmd),
        .o_ctl_addr       (ctl_addr),
        .o_ctl_wdata      (ctl_wdata),
        .i_ctl_rvalid     (ctl_rvalid),
        .i_ctl_rdata      (ctl_rdata),
        .o_cpu_rvalid     (cpu_rvalid),
        .o_cpu_rdata      (cpu_rdata),
        .o_count          (count),
        .o_rd_outstanding (rd_outstanding),
        .o_error          (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic cmd, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ctl_return(input logic [DATA_W-1:0] data);
        ctl_rvalid = 1'b1;
        ctl_rdata  = data;
        tick();
        ctl_rvalid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        ctl_ready  = 1'b0;
        ctl_rvalid = 1'b0;
        ctl_rdata  = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rd_out", 64'(rd_outstanding), 64'd0);
        chk("rst_ctl_valid", 64'(ctl_valid), 64'd0);
        chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        chk("rst_cpu_rdata", cpu_rdata, 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // Single write passes straight through.
        ctl_ready = 1'b1;
        push_one(1'b1, 27'h0000100, 64'hDEADBEEF_01234567);
        chk("t1_ctl_valid", 64'(ctl_valid), 64'd1);
        chk("t1_ctl_cmd", 64'(ctl_cmd), 64'd1);
        chk("t1_ctl_addr", 64'(ctl_addr), 64'h100);
        chk("t1_ctl_wdata", ctl_wdata, 64'hDEADBEEF_01234567);
        tick();
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_ctl_valid_off", 64'(ctl_valid), 64'd0);

        // Fill to full, hold a 9th request, then drain in order.
        ctl_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_one(1'b1, 27'(32'h10 + i), 64'(i) * 64'h1111);
        end
        chk("t2_count_full", 64'(count), 64'd8);
        chk("t2_ready_full", 64'(req_ready), 64'd0);
        req_valid = 1'b1;
        req_cmd   = 1'b1;
        req_addr  = 27'h99;
        req_wdata = 64'hCAFE;
        tick();
        tick();
        chk("t2_count_held", 64'(count), 64'd8);
        ctl_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("t2_order_valid", 64'(ctl_valid), 64'd1);
            chk("t2_order_addr", 64'(ctl_addr), (i < 8) ? 64'(32'h10 + i) : 64'h99);
            chk("t2_order_wdata", ctl_wdata, (i < 8) ? 64'(i) * 64'h1111 : 64'hCAFE);
            tick();
            if (i == 1) req_valid = 1'b0;
        end
        chk("t2_count_empty", 64'(count), 64'd0);

        // Read cap: 6 reads queued, only 4 may issue.
        ctl_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_one(1'b0, 27'(32'h200 + i), 64'd0);
        end
        ctl_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t3_rd_out_cap", 64'(rd_outstanding), 64'd4);
        chk("t3_count", 64'(count), 64'd2);
        chk("t3_ctl_valid_blocked", 64'(ctl_valid), 64'd0);
        chk("t3_head_addr", 64'(ctl_addr), 64'h204);
        ctl_return(64'h1111_2222_3333_4444);
        chk("t3_rd_out_after_ret", 64'(rd_outstanding), 64'd3);
        chk("t3_ctl_valid_resume", 64'(ctl_valid), 64'd1);
        chk("t3_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("t3_cpu_rdata", cpu_rdata, 64'h1111_2222_3333_4444);
        tick();
        chk("t3_rd_out_5th", 64'(rd_outstanding), 64'd4);
        chk("t3_count_5th", 64'(count), 64'd1);
        chk("t3_cpu_rvalid_pulse", 64'(cpu_rvalid), 64'd0);

        // Simultaneous read pop and return at outstanding == 2.
        ctl_ready = 1'b0;
        ctl_return(64'hA1);
        ctl_return(64'hA2);
        chk("t4_rd_out_two", 64'(rd_outstanding), 64'd2);
        chk("t4_ctl_valid", 64'(ctl_valid), 64'd1);
        ctl_ready = 1'b1;
        ctl_return(64'h5555_6666_7777_8888);
        chk("t4_rd_out_same", 64'(rd_outstanding), 64'd2);
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("t4_cpu_rdata", cpu_rdata, 64'h5555_6666_7777_8888);
        tick();
        chk("t4_cpu_rvalid_low", 64'(cpu_rvalid), 64'd0);
        chk("t4_cpu_rdata_hold", cpu_rdata, 64'h5555_6666_7777_8888);
        ctl_return(64'hB1);
        ctl_return(64'hB2);
        chk("t4_rd_out_drained", 64'(rd_outstanding), 64'd0);
        chk("t4_error_clear", 64'(error), 64'd0);

        // Unexpected return data.
        ctl_return(64'hBAD0_0000_0000_0001);
        chk("t5_error", 64'(error), 64'd1);
        chk("t5_rd_out_zero", 64'(rd_outstanding), 64'd0);
        chk("t5_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("t5_cpu_rdata", cpu_rdata, 64'hBAD0_0000_0000_0001);
        tick();
        tick();
        chk("t5_error_sticky", 64'(error), 64'd1);

        // Reset mid-operation with 5 queued and 3 outstanding.
        ctl_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(1'b0, 27'(32'h300 + i), 64'd0);
        for (int i = 0; i < 5; i++) push_one(1'b1, 27'(32'h400 + i), 64'(i + 1));
        ctl_ready = 1'b1;
        tick();
        tick();
        tick();
        ctl_ready = 1'b0;
        chk("t6_pre_count", 64'(count), 64'd5);
        chk("t6_pre_rd_out", 64'(rd_outstanding), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_rd_out", 64'(rd_outstanding), 64'd0);
        chk("t6_rst_ctl_valid", 64'(ctl_valid), 64'd0);
        chk("t6_rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        chk("t6_rst_cpu_rdata", cpu_rdata, 64'd0);
        chk("t6_rst_error", 64'(error), 64'd0);
        chk("t6_rst_req_ready", 64'(req_ready), 64'd1);
        tick();
        rst_n     = 1'b1;
        ctl_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_post_ctl_valid", 64'(ctl_valid), 64'd0);
            chk("t6_post_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        end
        chk("t6_post_count", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
